// File: rtl/input_source_arbiter.sv
// input_source_arbiter
// Chooses which controller source (keypad, IR or Bluetooth) drives the SNES
// button word. The DIP switches either pin one source (FORCED) or enable auto
// arbitration. In auto mode the first active source, ranked key > ir > bt,
// takes ownership. It keeps ownership until its own button word has been all
// zero for IDLE_TIMEOUT consecutive cycles.
// All outputs are registered and take effect one edge after the inputs that
// caused them.

module input_source_arbiter #(
  parameter int unsigned IDLE_TIMEOUT = 50000,
  // Derived timer width; do not override.
  parameter int unsigned TW           = $clog2(IDLE_TIMEOUT + 1)
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] key_btn,
  input  logic [7:0] ir_btn,
  input  logic [7:0] bt_btn,
  input  logic [1:0] dip,
  output logic [1:0] sel,
  output logic [7:0] btn_out,
  output logic       owner_valid,
  output logic       switch_pulse
);

  // Source select encodings as they appear on sel.
  localparam logic [1:0] SRC_KEY = 2'd0;
  localparam logic [1:0] SRC_IR  = 2'd1;
  localparam logic [1:0] SRC_BT  = 2'd2;

  // A DIP value of 3 enables auto arbitration. Any other value forces a source.
  localparam logic [1:0] DIP_AUTO = 2'd3;

  // Reload value for the idle timer. It is sized to the timer width.
  localparam logic [TW-1:0] TIMER_RELOAD = TW'(IDLE_TIMEOUT);
  localparam logic [TW-1:0] TIMER_ONE    = TW'(1);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,  // auto mode, no owner
    ST_OWNED  = 2'd1,  // auto mode, sel_q names the owner
    ST_FORCED = 2'd2   // DIP pins the source
  } state_e;

  state_e        state_q, state_d;
  logic [1:0]    sel_q,   sel_d;
  logic [7:0]    btn_q,   btn_d;
  logic          valid_q, valid_d;
  logic          pulse_q, pulse_d;
  logic [TW-1:0] timer_q, timer_d;

  // Source word lookup. The unused encoding 3 yields zero, so it can never
  // leak a button word.
  function automatic logic [7:0] src_word(input logic [1:0] s,
                                          input logic [7:0] k,
                                          input logic [7:0] i,
                                          input logic [7:0] b);
    logic [7:0] w;
    w = 8'h00;
    unique case (s)
      SRC_KEY: w = k;
      SRC_IR:  w = i;
      SRC_BT:  w = b;
      default: w = 8'h00;
    endcase
    return w;
  endfunction

  // Signals used by the auto-mode grant and the ownership timer.
  logic       any_active;
  logic [1:0] winner;
  logic [7:0] winner_word;
  logic [7:0] owner_word;
  logic [7:0] forced_word;

  // Fixed-priority winner among the active sources (key > ir > bt).
  always_comb begin
    // NOTE: every combinational output gets a default value before any branch.
    // If a path leaves a signal unassigned, synthesis infers a latch for it.
    winner = SRC_KEY;
    if (key_btn != 8'h00)     winner = SRC_KEY;
    else if (ir_btn != 8'h00) winner = SRC_IR;
    else if (bt_btn != 8'h00) winner = SRC_BT;
    any_active  = (key_btn != 8'h00) || (ir_btn != 8'h00) || (bt_btn != 8'h00);
    winner_word = src_word(winner, key_btn, ir_btn, bt_btn);
    owner_word  = src_word(sel_q,  key_btn, ir_btn, bt_btn);
    forced_word = src_word(dip,    key_btn, ir_btn, bt_btn);
  end

  // Next-state, next-output and timer logic.
  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    btn_d   = btn_q;
    valid_d = valid_q;
    timer_d = timer_q;

    if (dip != DIP_AUTO) begin
      // A forced DIP setting overrides any auto-mode state on every edge.
      state_d = ST_FORCED;
      sel_d   = dip;
      btn_d   = forced_word;
      valid_d = 1'b1;
      timer_d = '0;
    end else begin
      unique case (state_q)
        ST_FORCED: begin
          // Leaving forced mode: drop the word and keep sel where it was.
          state_d = ST_IDLE;
          btn_d   = 8'h00;
          valid_d = 1'b0;
          timer_d = '0;
        end

        ST_IDLE: begin
          btn_d   = 8'h00;
          valid_d = 1'b0;
          timer_d = '0;
          if (any_active) begin
            state_d = ST_OWNED;
            sel_d   = winner;
            btn_d   = winner_word;
            valid_d = 1'b1;
            timer_d = TIMER_RELOAD;
          end
        end

        ST_OWNED: begin
          // Only the owner's word matters here. Other sources are ignored.
          btn_d   = owner_word;
          valid_d = 1'b1;
          if (owner_word != 8'h00) begin
            timer_d = TIMER_RELOAD;
          end else if (timer_q > TIMER_ONE) begin
            timer_d = timer_q - TIMER_ONE;
          end else begin
            // This is the IDLE_TIMEOUT-th consecutive idle cycle: release.
            // A timer of 0 here is never reached in normal operation. It is
            // also treated as a release, so the timer can never wrap.
            state_d = ST_IDLE;
            timer_d = '0;
            valid_d = 1'b0;
            btn_d   = 8'h00;
          end
        end

        default: begin
          // Unreachable encoding: fall back to a clean auto-idle state.
          state_d = ST_IDLE;
          btn_d   = 8'h00;
          valid_d = 1'b0;
          timer_d = '0;
        end
      endcase
    end

    // Pulse exactly on the edge where sel takes a different value.
    pulse_d = (sel_d != sel_q);
  end

  // State, output and timer registers with asynchronous reset.
  always_ff @(posedge clk or posedge reset) begin
    // NOTE: sequential state uses non-blocking assignments so that every flop
    // samples the values from before the edge, whatever the statement order.
    // The design holds only a few flops and no memories, so all of them are
    // reset.
    if (reset) begin
      state_q <= ST_IDLE;
      sel_q   <= SRC_KEY;
      btn_q   <= 8'h00;
      valid_q <= 1'b0;
      pulse_q <= 1'b0;
      timer_q <= '0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      btn_q   <= btn_d;
      valid_q <= valid_d;
      pulse_q <= pulse_d;
      timer_q <= timer_d;
    end
  end

  assign sel          = sel_q;
  assign btn_out      = btn_q;
  assign owner_valid  = valid_q;
  assign switch_pulse = pulse_q;

`ifndef SYNTHESIS
  // The select must never carry the auto-mode encoding.
  a_sel_legal : assert property (@(posedge clk) disable iff (reset)
    sel_q != DIP_AUTO);

  // owner_valid must track whether some source is driving btn_out.
  a_valid_state : assert property (@(posedge clk) disable iff (reset)
    valid_q == (state_q != ST_IDLE));

  // The idle timer runs only while a source owns the bus.
  a_timer_owned : assert property (@(posedge clk) disable iff (reset)
    (state_q != ST_OWNED) |-> (timer_q == '0));
`endif

endmodule

// File: tb/tb_input_source_arbiter.sv
// Directed testbench for input_source_arbiter, run with IDLE_TIMEOUT = 4.
// Inputs are driven 1 time unit after a rising edge. Outputs are sampled at
// that same point, which is well away from the next edge.
// Each observation packs {sel, btn_out, owner_valid, switch_pulse} into 12 bits.

module tb_input_source_arbiter;

  localparam int unsigned TO = 4;

  logic       clk;
  logic       reset;
  logic [7:0] key_btn;
  logic [7:0] ir_btn;
  logic [7:0] bt_btn;
  logic [1:0] dip;
  logic [1:0] sel;
  logic [7:0] btn_out;
  logic       owner_valid;
  logic       switch_pulse;

  int checks;
  int errors;

  logic [11:0] obs;
  logic [11:0] exp_v;

  assign obs = {sel, btn_out, owner_valid, switch_pulse};

  input_source_arbiter #(.IDLE_TIMEOUT(TO)) dut (
    .clk          (clk),
    .reset        (reset),
    .key_btn      (key_btn),
    .ir_btn       (ir_btn),
    .bt_btn       (bt_btn),
    .dip          (dip),
    .sel          (sel),
    .btn_out      (btn_out),
    .owner_valid  (owner_valid),
    .switch_pulse (switch_pulse)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one rising edge and settle 1 time unit after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_in(input logic [1:0] d, input logic [7:0] k,
                        input logic [7:0] i, input logic [7:0] b);
    dip     = d;
    key_btn = k;
    ir_btn  = i;
    bt_btn  = b;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    set_in(2'd3, 8'h00, 8'h00, 8'h00);
    step();
    step();
    exp_v = {2'd0, 8'h00, 1'b0, 1'b0};
    checks++;
    if (obs !== exp_v) begin
      errors++;
      $display("FAIL reset_state: got %h want %h", obs, exp_v);
    end
    reset = 1'b0;
    step();
    checks++;
    if (obs !== exp_v) begin
      errors++;
      $display("FAIL idle_after_reset: got %h want %h", obs, exp_v);
    end
  endtask

  task automatic test_forced();
    set_in(2'd1, 8'h00, 8'hA5, 8'h00);
    step();
    exp_v = {2'd1, 8'hA5, 1'b1, 1'b1};
    checks++;
    if (obs !== exp_v) begin
      errors++;
      $display("FAIL forced_ir: got %h want %h", obs, exp_v);
    end
    step();
    exp_v = {2'd1, 8'hA5, 1'b1, 1'b0};
    checks++;
    if (obs !== exp_v) begin
      errors++;
      $display("FAIL forced_pulse_once: got %h want %h", obs, exp_v);
    end
    set_in(2'd2, 8'h00, 8'hA5, 8'h3C);
    step();
    exp_v = {2'd2, 8'h3C, 1'b1, 1'b1};
    checks++;
    if (obs !== exp_v) begin
      errors++;
      $display("FAIL forced_switch_bt: got %h want %h", obs, exp_v);
    end
    set_in(2'd3, 8'h00, 8'h00, 8'h00);
    step();
    exp_v = {2'd2, 8'h00, 1'b0, 1'b0};
    checks++;
    if (obs !== exp_v) begin
      errors++;
      $display("FAIL leave_forced: got %h want %h", obs, exp_v);
    end
  endtask

  task automatic test_auto_priority();
    // sel is 2 at this point, so the grant to ir must pulse.
    set_in(2'd3, 8'h00, 8'h0F, 8'hF0);
    step();
    exp_v = {2'd1, 8'h0F, 1'b1, 1'b1};
    checks++;
    if (obs !== exp_v) begin
      errors++;
      $display("FAIL grant_ir: got %h want %h", obs, exp_v);
    end
    set_in(2'd3, 8'h00, 8'h01, 8'hFF);
    step();
    exp_v = {2'd1, 8'h01, 1'b1, 1'b0};
    checks++;
    if (obs !== exp_v) begin
      errors++;
      $display("FAIL owner_ignores_bt: got %h want %h", obs, exp_v);
    end
    set_in(2'd3, 8'h00, 8'h00, 8'h00);
    for (int n = 1; n <= 3; n++) begin
      step();
      exp_v = {2'd1, 8'h00, 1'b1, 1'b0};
      checks++;
      if (obs !== exp_v) begin
        errors++;
        $display("FAIL ir_hold_zero%0d: got %h want %h", n, obs, exp_v);
      end
    end
    step();
    exp_v = {2'd1, 8'h00, 1'b0, 1'b0};
    checks++;
    if (obs !== exp_v) begin
      errors++;
      $display("FAIL ir_release: got %h want %h", obs, exp_v);
    end
  endtask

  task automatic test_timeout();
    set_in(2'd3, 8'h00, 8'h00, 8'h80);
    step();
    exp_v = {2'd2, 8'h80, 1'b1, 1'b1};
    checks++;
    if (obs !== exp_v) begin
      errors++;
      $display("FAIL grant_bt: got %h want %h", obs, exp_v);
    end
    // Three idle owner cycles while ir is active: ir must stay ignored.
    set_in(2'd3, 8'h00, 8'h55, 8'h00);
    for (int n = 1; n <= 3; n++) begin
      step();
      exp_v = {2'd2, 8'h00, 1'b1, 1'b0};
      checks++;
      if (obs !== exp_v) begin
        errors++;
        $display("FAIL bt_zero%0d: got %h want %h", n, obs, exp_v);
      end
    end
    set_in(2'd3, 8'h00, 8'h00, 8'h80);
    step();
    exp_v = {2'd2, 8'h80, 1'b1, 1'b0};
    checks++;
    if (obs !== exp_v) begin
      errors++;
      $display("FAIL bt_reload: got %h want %h", obs, exp_v);
    end
    set_in(2'd3, 8'h00, 8'h00, 8'h00);
    for (int n = 1; n <= 3; n++) begin
      step();
      exp_v = {2'd2, 8'h00, 1'b1, 1'b0};
      checks++;
      if (obs !== exp_v) begin
        errors++;
        $display("FAIL bt_after_reload%0d: got %h want %h", n, obs, exp_v);
      end
    end
    step();
    exp_v = {2'd2, 8'h00, 1'b0, 1'b0};
    checks++;
    if (obs !== exp_v) begin
      errors++;
      $display("FAIL bt_release: got %h want %h", obs, exp_v);
    end
  endtask

  task automatic test_simultaneous();
    set_in(2'd3, 8'h01, 8'h00, 8'h01);
    step();
    exp_v = {2'd0, 8'h01, 1'b1, 1'b1};
    checks++;
    if (obs !== exp_v) begin
      errors++;
      $display("FAIL key_beats_bt: got %h want %h", obs, exp_v);
    end
    set_in(2'd3, 8'h00, 8'h00, 8'h00);
    for (int n = 1; n <= 4; n++) step();
    exp_v = {2'd0, 8'h00, 1'b0, 1'b0};
    checks++;
    if (obs !== exp_v) begin
      errors++;
      $display("FAIL key_release: got %h want %h", obs, exp_v);
    end
    // Re-grant to the same source: no pulse.
    set_in(2'd3, 8'h02, 8'h00, 8'h00);
    step();
    exp_v = {2'd0, 8'h02, 1'b1, 1'b0};
    checks++;
    if (obs !== exp_v) begin
      errors++;
      $display("FAIL regrant_same_no_pulse: got %h want %h", obs, exp_v);
    end
  endtask

  task automatic test_force_from_owned();
    set_in(2'd2, 8'h02, 8'h00, 8'h77);
    step();
    exp_v = {2'd2, 8'h77, 1'b1, 1'b1};
    checks++;
    if (obs !== exp_v) begin
      errors++;
      $display("FAIL owned_to_forced: got %h want %h", obs, exp_v);
    end
    // Back to auto with bt still active: IDLE first, grant on the next edge.
    set_in(2'd3, 8'h00, 8'h00, 8'h77);
    step();
    exp_v = {2'd2, 8'h00, 1'b0, 1'b0};
    checks++;
    if (obs !== exp_v) begin
      errors++;
      $display("FAIL forced_to_idle: got %h want %h", obs, exp_v);
    end
    step();
    exp_v = {2'd2, 8'h77, 1'b1, 1'b0};
    checks++;
    if (obs !== exp_v) begin
      errors++;
      $display("FAIL regrant_after_idle: got %h want %h", obs, exp_v);
    end
  endtask

  task automatic test_async_reset();
    // bt owns the bus here. Assert reset between edges.
    #2;
    reset = 1'b1;
    #1;
    exp_v = {2'd0, 8'h00, 1'b0, 1'b0};
    checks++;
    if (obs !== exp_v) begin
      errors++;
      $display("FAIL async_reset: got %h want %h", obs, exp_v);
    end
    #1;
    reset = 1'b0;
    set_in(2'd0, 8'h5A, 8'h00, 8'h77);
    step();
    exp_v = {2'd0, 8'h5A, 1'b1, 1'b0};
    checks++;
    if (obs !== exp_v) begin
      errors++;
      $display("FAIL forced_after_reset: got %h want %h", obs, exp_v);
    end
  endtask

  // Guard against a run that never finishes.
  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    checks = 0;
    errors = 0;
    reset  = 1'b1;
    set_in(2'd3, 8'h00, 8'h00, 8'h00);
    test_reset();
    test_forced();
    test_auto_priority();
    test_timeout();
    test_simultaneous();
    test_force_from_owned();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
